// File: rtl/alu_operand_loader_if.sv
// Board-side and ALU-side signals of the operand loader, bundled so the
// loader and its driver connect through one port.
interface alu_operand_loader_if #(
    parameter int WIDTH    = 4,
    parameter int OP_WIDTH = 4
);
    logic [WIDTH-1:0]    sw;
    logic [OP_WIDTH-1:0] op_sw;
    logic                btn;
    logic [WIDTH-1:0]    operand_a;
    logic [WIDTH-1:0]    operand_b;
    logic [OP_WIDTH-1:0] opcode;
    logic                alu_en;
    logic [1:0]          stage;

    // Loader side: samples the board inputs, drives the ALU inputs and capture strobe.
    modport master (
        input  sw, op_sw, btn,
        output operand_a, operand_b, opcode, alu_en, stage
    );

    // Board/ALU side: drives switches and button, observes the loaded values.
    modport slave (
        output sw, op_sw, btn,
        input  operand_a, operand_b, opcode, alu_en, stage
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects operand A, operand B and opcode on debounced button presses and
// issues a one-cycle capture strobe to the ALU result register.
module alu_operand_loader #(
    parameter int WIDTH           = 4,
    parameter int OP_WIDTH        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_loader_if.master bus
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_OP,
        S_EXEC,
        S_SHOW
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_sync;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_db;
    logic                r_db_d;
    logic                w_press;
    logic                w_load_a;
    logic                w_load_b;
    logic                w_load_op;
    logic [WIDTH-1:0]    r_operand_a;
    logic [WIDTH-1:0]    r_operand_b;
    logic [OP_WIDTH-1:0] r_opcode;
    logic                r_alu_en;
    logic [1:0]          w_stage;

    // The counter only runs while the synchronized level disagrees with r_db;
    // the DEBOUNCE_CYCLES-th disagreeing sample flips r_db.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bus.btn};
            r_db_d <= r_db;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db & ~r_db_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_op    = 1'b0;
        w_stage      = 2'b00;
        case (r_state)
            S_LOAD_A: begin
                w_stage = 2'b00;
                if (w_press) begin
                    w_load_a     = 1'b1;
                    w_state_next = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                w_stage = 2'b01;
                if (w_press) begin
                    w_load_b     = 1'b1;
                    w_state_next = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                w_stage = 2'b10;
                if (w_press) begin
                    w_load_op    = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_stage      = 2'b11;
                w_state_next = S_SHOW;
            end
            S_SHOW: begin
                w_stage = 2'b11;
                if (w_press) begin
                    w_load_a     = 1'b1;
                    w_state_next = S_LOAD_B;
                end
            end
            default: begin
                w_state_next = S_LOAD_A;
            end
        endcase
    end

    // The strobe is registered from the next state so it is high exactly
    // during the EXEC cycle, with no combinational path to the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_alu_en    <= 1'b0;
        end else begin
            r_alu_en <= (w_state_next == S_EXEC);
            if (w_load_a) begin
                r_operand_a <= bus.sw;
            end
            if (w_load_b) begin
                r_operand_b <= bus.sw;
            end
            if (w_load_op) begin
                r_opcode <= bus.op_sw;
            end
        end
    end

    assign bus.operand_a = r_operand_a;
    assign bus.operand_b = r_operand_b;
    assign bus.opcode    = r_opcode;
    assign bus.alu_en    = r_alu_en;
    assign bus.stage     = w_stage;
endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a 4-cycle debounce.
module tb_alu_operand_loader;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_operand_loader_if #(.WIDTH(4), .OP_WIDTH(4)) bus ();

    alu_operand_loader #(
        .WIDTH(4),
        .OP_WIDTH(4),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] op_sw;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [3:0] exp_op;
        logic [1:0] exp_stage;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean button press: held high for hi cycles, then low for lo cycles.
    task automatic press(input logic [3:0] s, input logic [3:0] o,
                         input int hi, input int lo, output int pulses);
        pulses    = 0;
        bus.sw    = s;
        bus.op_sw = o;
        bus.btn   = 1'b1;
        for (int i = 0; i < hi; i++) begin
            tick();
            if (bus.alu_en) pulses++;
        end
        bus.btn = 1'b0;
        for (int i = 0; i < lo; i++) begin
            tick();
            if (bus.alu_en) pulses++;
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] op, input logic [1:0] st);
        check({tag, ".operand_a"}, int'(bus.operand_a), int'(a));
        check({tag, ".operand_b"}, int'(bus.operand_b), int'(b));
        check({tag, ".opcode"},    int'(bus.opcode),    int'(op));
        check({tag, ".stage"},     int'(bus.stage),     int'(st));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         pulses;
        int         load_edge;
        int         seen;
        logic [3:0] m_a, m_b, m_op;
        int         m_step;
        logic [3:0] s, o;
        int         exp_p;

        bus.sw    = 4'h0;
        bus.op_sw = 4'h0;
        bus.btn   = 1'b0;

        // Reset values, before any clock edge
        #3;
        check_outputs("reset", 4'h0, 4'h0, 4'h0, 2'b00);
        check("reset.alu_en", int'(bus.alu_en), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("post_release.stage", int'(bus.stage), 0);

        // Exact latency of the first load: btn sampled high at edge 1, load at edge D+3
        bus.sw    = 4'h5;
        bus.btn   = 1'b1;
        load_edge = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (load_edge < 0 && bus.operand_a == 4'h5) load_edge = n;
        end
        check("latency.load_edge", load_edge, D + 3);
        check("latency.stage", int'(bus.stage), 1);
        bus.btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Table-driven press sequence: completes the operation, then restarts from SHOW
        vecs[0] = '{4'h3, 4'h0, 4'h5, 4'h3, 4'h0, 2'd2, 0};
        vecs[1] = '{4'h0, 4'h2, 4'h5, 4'h3, 4'h2, 2'd3, 1};
        vecs[2] = '{4'hA, 4'h7, 4'hA, 4'h3, 4'h2, 2'd1, 0};
        vecs[3] = '{4'h6, 4'h7, 4'hA, 4'h6, 4'h2, 2'd2, 0};
        vecs[4] = '{4'h1, 4'hF, 4'hA, 4'h6, 4'hF, 2'd3, 1};
        for (int v = 0; v < 5; v++) begin
            press(vecs[v].sw, vecs[v].op_sw, 10, 10, pulses);
            check_outputs($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b,
                          vecs[v].exp_op, vecs[v].exp_stage);
            check($sformatf("vec%0d.pulses", v), pulses, vecs[v].exp_pulses);
        end

        // Asynchronous reset in mid-cycle clears outputs without a clock edge
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_outputs("async_reset", 4'h0, 4'h0, 4'h0, 2'b00);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("async_reset.stays_load_a", int'(bus.stage), 0);

        // Bounce: 1,0,1,0 then hold 1; single load timed from the final rise
        bus.sw = 4'h7;
        for (int i = 0; i < 4; i++) begin
            bus.btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        bus.btn   = 1'b1;
        load_edge = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (load_edge < 0 && bus.operand_a == 4'h7) begin
                load_edge = n;
                bus.sw    = 4'h9;
            end
        end
        check("bounce.load_edge", load_edge, D + 3);
        check("bounce.operand_a", int'(bus.operand_a), 7);
        check("bounce.stage", int'(bus.stage), 1);
        bus.btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Long hold: 50 cycles high, switch changed after the load must not reload
        bus.sw  = 4'h4;
        bus.btn = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 12) bus.sw = 4'hE;
            if (bus.alu_en) pulses++;
        end
        bus.btn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_outputs("long_hold", 4'h7, 4'h4, 4'h0, 2'b10);
        check("long_hold.pulses", pulses, 0);

        // Opcode press: strobe aligned with opcode update, then reset during EXEC
        bus.op_sw = 4'h1;
        bus.btn   = 1'b1;
        seen      = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            tick();
            if (bus.alu_en) begin
                seen = 1;
                check("exec.opcode", int'(bus.opcode), 1);
                check("exec.stage", int'(bus.stage), 3);
                #1;
                rst = 1'b0;
                #1;
                check("exec_reset.alu_en", int'(bus.alu_en), 0);
                check("exec_reset.stage", int'(bus.stage), 0);
                check("exec_reset.operand_b", int'(bus.operand_b), 0);
            end
        end
        check("exec.seen", seen, 1);
        bus.btn = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        press(4'h2, 4'h0, 10, 10, pulses);
        check("after_reset.press1.pulses", pulses, 0);
        press(4'h3, 4'h0, 10, 10, pulses);
        check("after_reset.press2.pulses", pulses, 0);
        press(4'h0, 4'h6, 10, 10, pulses);
        check("after_reset.press3.pulses", pulses, 1);
        check_outputs("after_reset", 4'h2, 4'h3, 4'h6, 2'b11);

        // Randomized presses against a per-press reference model
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        m_a = 4'h0; m_b = 4'h0; m_op = 4'h0; m_step = 0;
        for (int t = 0; t < 24; t++) begin
            s = 4'($urandom_range(0, 15));
            o = 4'($urandom_range(0, 15));
            press(s, o, int'($urandom_range(8, 14)), int'($urandom_range(7, 12)), pulses);
            exp_p = 0;
            case (m_step)
                0, 3: begin m_a = s;  m_step = 1; end
                1:    begin m_b = s;  m_step = 2; end
                default: begin m_op = o; m_step = 3; exp_p = 1; end
            endcase
            check_outputs($sformatf("rand%0d", t), m_a, m_b, m_op, 2'(m_step));
            check($sformatf("rand%0d.pulses", t), pulses, exp_p);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
